// File: rtl/root_fanin_collector.sv
// Five-input round-robin fan-in into a single-entry output register.
// Counts accepted beats in a saturating counter.
module root_fanin_collector #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          in_valid,
    input  logic [5*DATA_W-1:0] in_data,
    output logic [4:0]          in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [2:0]          out_src,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    beat_count
);

    // Handshake: a beat moves on a rising edge exactly when valid && ready are both 1;
    // valid never waits on ready, and a held out_valid beat keeps out_data/out_src stable.

    logic [2:0]        ptr;
    logic              take;
    logic              any_valid;
    logic              grant;
    logic [2:0]        win;
    logic [3:0]        sum;
    logic [3:0]        idx;
    logic [DATA_W-1:0] win_data;

    assign take  = !out_valid || out_ready;
    assign grant = take && any_valid && !rst;

    // Search ptr, ptr+1, ... modulo 5; the first valid channel wins.
    always_comb begin
        any_valid = 1'b0;
        win       = 3'd0;
        sum       = 4'd0;
        idx       = 4'd0;
        for (int k = 0; k < 5; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            idx = (sum >= 4'd5) ? (sum - 4'd5) : sum;
            if (!any_valid && in_valid[idx]) begin
                any_valid = 1'b1;
                win       = idx[2:0];
            end
        end
    end

    // Payload mux uses constant slices so in_data never steers the grant.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < 5; i++) begin
            if (win == 3'(i)) begin
                win_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_ready = grant ? (5'b00001 << win) : 5'b00000;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= 3'd0;
            ptr        <= 3'd0;
            beat_count <= '0;
        end else begin
            if (grant) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_src   <= win;
                ptr       <= (win == 3'd4) ? 3'd0 : (win + 3'd1);
                if (beat_count != {CNT_W{1'b1}}) begin
                    beat_count <= beat_count + 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
